// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: pipeline constants, bus widths and the
// fetch FSM state encoding.
package if_fetch_queue_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic Stop      = 1'b1;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  localparam int unsigned FetchQueueDepth = 4;
  localparam int unsigned FqStateBus      = 2;

  typedef enum logic [FqStateBus-1:0] {
    FqIdle    = 2'd0,
    FqWaitAck = 2'd1,
    FqDrain   = 2'd2
  } fq_state_e;

endpackage

// File: rtl/if_fetch_queue_mem.sv
// Fetch queue storage: circular buffer with read/write pointers and an occupancy count.
// Pop on empty is ignored; clear resets pointers and count but leaves storage untouched.
module fetch_fifo_mem
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty && !clear;
  // A push into a full queue is allowed only when the head leaves in the same cycle.
  assign do_push = push && !clear && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues PCs to instruction memory (one outstanding request), buffers
// {pc, inst} pairs and presents the head to IF/ID. Define FETCH_QUEUE_BYPASS_EN for 0-cycle bypass.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FetchQueueDepth,
  parameter int unsigned ADDR_W = InstAddrBus,
  parameter int unsigned DATA_W = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              stallreq_o,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ack_i,
  input  logic [DATA_W-1:0] inst_data_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o
);

  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned EntryW = ADDR_W + DATA_W;

  fq_state_e         state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;

  logic [CntW-1:0]   count;
  logic              empty;
  logic [EntryW-1:0] head;
  logic [CntW-1:0]   reserved;
  logic              ack_fire;
  logic              accept;
  logic              bypass;
  logic              pop_out;
  logic              fifo_push;
  logic              fifo_pop;
  logic              unused_stall;

  assign unused_stall = ^{stall[5:2], stall[0]};

  assign ack_fire = (state_q == FqWaitAck) && inst_ack_i;
  // An outstanding live request already owns a queue slot.
  assign reserved = count + CntW'(state_q == FqWaitAck);

  assign stallreq_o = !flush_i && ((state_q == FqDrain) ||
                                   ((state_q == FqWaitAck) && !inst_ack_i) ||
                                   (reserved == CntW'(DEPTH)));

  assign accept = pc_valid_i && !stallreq_o && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && ack_fire;
`else
  assign bypass = 1'b0;
`endif

  assign pop_out   = if_valid_o && (stall[1] == NoStop);
  // A bypassed word that IF/ID takes this cycle never needs to be stored.
  assign fifo_push = ack_fire && !flush_i && !(bypass && pop_out);
  assign fifo_pop  = pop_out && !bypass;

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (fifo_push),
    .wdata ({addr_q, inst_data_i}),
    .pop   (fifo_pop),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_comb begin
    if_valid_o = 1'b0;
    if_pc_o    = '0;
    if_inst_o  = DATA_W'(ZeroWord);
    if (bypass) begin
      if_valid_o = 1'b1;
      if_pc_o    = addr_q;
      if_inst_o  = inst_data_i;
    end else if (!empty) begin
      if_valid_o = 1'b1;
      if_pc_o    = head[EntryW-1:DATA_W];
      if_inst_o  = head[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= FqIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else if (flush_i) begin
      // Flushed work: a pending request must still complete, but its data is dropped.
      unique case (state_q)
        FqWaitAck, FqDrain: begin
          if (inst_ack_i) begin
            state_q <= FqIdle;
            req_q   <= 1'b0;
          end else begin
            state_q <= FqDrain;
          end
        end
        default: begin
          state_q <= FqIdle;
          req_q   <= 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        FqIdle: begin
          if (accept) begin
            state_q <= FqWaitAck;
            req_q   <= 1'b1;
            addr_q  <= pc_i;
          end
        end
        FqWaitAck: begin
          if (inst_ack_i) begin
            if (accept) begin
              addr_q <= pc_i;
            end else begin
              state_q <= FqIdle;
              req_q   <= 1'b0;
            end
          end
        end
        FqDrain: begin
          if (inst_ack_i) begin
            state_q <= FqIdle;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= FqIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign inst_req_o  = req_q;
  assign inst_addr_o = addr_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch_queue;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        flush_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        stallreq_o;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_ack_i = 1'b0;
  logic [31:0] inst_data_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int tests_run = 0;
  int tests_failed = 0;

  if_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush_i     (flush_i),
    .pc_i        (pc_i),
    .pc_valid_i  (pc_valid_i),
    .stallreq_o  (stallreq_o),
    .inst_req_o  (inst_req_o),
    .inst_addr_o (inst_addr_o),
    .inst_ack_i  (inst_ack_i),
    .inst_data_i (inst_data_i),
    .if_valid_o  (if_valid_o),
    .if_pc_o     (if_pc_o),
    .if_inst_o   (if_inst_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched pairs plus the outstanding-request status.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          m_out;
  bit          m_drain;
  logic [31:0] m_addr;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_out   = 1'b0;
      m_drain = 1'b0;
      m_addr  = '0;
    end else begin
      bit          live;
      bit          ack;
      bit          e_stall;
      bit          byp;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      int          reserved;
      live     = m_out && !m_drain;
      ack      = inst_ack_i;
      reserved = mq.size() + (live ? 1 : 0);
      e_stall  = !flush_i && (m_drain || (live && !ack) || reserved == Depth);
      byp      = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp      = (mq.size() == 0) && live && ack;
`endif
      e_valid = byp || (mq.size() > 0);
      e_pc    = byp ? m_addr : (mq.size() > 0 ? mq[0].pc : 32'h0);
      e_inst  = byp ? inst_data_i : (mq.size() > 0 ? mq[0].inst : 32'h0);
      chk("model_stallreq", 64'(stallreq_o), 64'(e_stall));
      chk("model_inst_req", 64'(inst_req_o), 64'(m_out));
      chk("model_inst_addr", 64'(inst_addr_o), 64'(m_addr));
      chk("model_if_valid", 64'(if_valid_o), 64'(e_valid));
      chk("model_if_pc", 64'(if_pc_o), 64'(e_pc));
      chk("model_if_inst", 64'(if_inst_o), 64'(e_inst));
      if (flush_i) begin
        mq.delete();
        if (m_out && ack) begin
          m_out   = 1'b0;
          m_drain = 1'b0;
        end else if (m_out) begin
          m_drain = 1'b1;
        end
      end else begin
        if (live && ack) begin
          mq.push_back('{pc: m_addr, inst: inst_data_i});
          m_out = 1'b0;
        end
        if (m_drain && ack) begin
          m_out   = 1'b0;
          m_drain = 1'b0;
        end
        if (e_valid && stall[1] == 1'b0) void'(mq.pop_front());
        if (pc_valid_i && !e_stall) begin
          m_out  = 1'b1;
          m_addr = pc_i;
        end
      end
    end
  end

  // Memory responder: fixed latency (cycles of req before ack) or random acks.
  int mem_lat = 0;
  bit mem_rand = 1'b0;
  int mcnt = 0;

  task automatic step(input bit pv, input logic [31:0] pc, input bit st1, input bit fl);
    logic [5:0] s;
    @(posedge clk);
    #1;
    s          = 6'($urandom);
    s[1]       = st1;
    stall      = s;
    pc_valid_i = pv;
    pc_i       = pc;
    flush_i    = fl;
    if (!inst_req_o || rst) begin
      mcnt       = 0;
      inst_ack_i = 1'b0;
    end else begin
      inst_ack_i = mem_rand ? ($urandom_range(0, 2) == 0) : (mcnt >= mem_lat);
      if (inst_ack_i) mcnt = 0;
      else mcnt++;
    end
    inst_data_i = $urandom;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    int          off;
    bit          acc;
    bit          found;
    logic [31:0] got[$];

    // Reset values
    #1;
    chk("rst_inst_req", 64'(inst_req_o), 64'h0);
    chk("rst_inst_addr", 64'(inst_addr_o), 64'h0);
    chk("rst_if_valid", 64'(if_valid_o), 64'h0);
    chk("rst_if_pc", 64'(if_pc_o), 64'h0);
    chk("rst_if_inst", 64'(if_inst_o), 64'h0);
    chk("rst_stallreq", 64'(stallreq_o), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;

    // Async reset in the middle of an outstanding request
    mem_lat = 100;
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("arst_req_before", 64'(inst_req_o), 64'h1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_req_dropped", 64'(inst_req_o), 64'h0);
    chk("arst_if_valid", 64'(if_valid_o), 64'h0);
    pc_valid_i = 1'b0;
    inst_ack_i = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("arst_stallreq_after", 64'(stallreq_o), 64'h0);
    chk("arst_req_after", 64'(inst_req_o), 64'h0);

    // Zero-wait memory, three back-to-back PCs
    mem_lat = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    off = 1;
`else
    off = 2;
`endif
    for (int k = 0; k < 6; k++) begin
      bit          ev;
      logic [31:0] ep;
      step(k < 3, 32'(4 * k), 1'b0, 1'b0);
      ev = (k >= off) && (k < off + 3);
      ep = ev ? 32'(4 * (k - off)) : 32'h0;
      chk("zw_if_valid", 64'(if_valid_o), 64'(ev));
      chk("zw_if_pc", 64'(if_pc_o), 64'(ep));
    end

    // IF/ID stalled: queue fills to Depth, then drains in order
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      step(idx < 6, 32'(4 * idx), 1'b1, 1'b0);
      if (idx < 6 && !stallreq_o) idx++;
    end
    chk("full_accepted", 64'(idx), 64'd4);
    chk("full_stallreq", 64'(stallreq_o), 64'h1);
    chk("full_head_valid", 64'(if_valid_o), 64'h1);
    chk("full_head_pc", 64'(if_pc_o), 64'h0);
    got.delete();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 32'h0, 1'b0, 1'b0);
      if (if_valid_o) got.push_back(if_pc_o);
    end
    chk("drain_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("drain_order", 64'(got[k]), 64'(4 * k));

    // Flush during a slow fetch: DRAIN holds req until ack, data dropped, then 0x100 accepted
    mem_lat = 3;
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("flush_req_held", 64'(inst_req_o), 64'h1);
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step(1'b1, 32'h100, 1'b0, 1'b0);
      chk("drain_if_valid", 64'(if_valid_o), 64'h0);
      if (!stallreq_o) acc = 1'b1;
      else chk("drain_req_held", 64'(inst_req_o), 64'h1);
    end
    chk("drain_accept", 64'(acc), 64'h1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_drain_addr", 64'(inst_addr_o), 64'h100);
    chk("post_drain_req", 64'(inst_req_o), 64'h1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (if_valid_o) begin
        found = 1'b1;
        chk("post_drain_pc", 64'(if_pc_o), 64'h100);
      end else begin
        step(1'b0, 32'h0, 1'b0, 1'b0);
      end
    end
    chk("post_drain_found", 64'(found), 64'h1);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0);

    // Flush coinciding with ack and pop while two entries are queued
    mem_lat = 0;
    step(1'b1, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h4, 1'b1, 1'b0);
    step(1'b1, 32'h8, 1'b1, 1'b0);
    chk("fap_two_queued", 64'(if_valid_o), 64'h1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fap_if_valid", 64'(if_valid_o), 64'h0);
    chk("fap_req", 64'(inst_req_o), 64'h0);
    chk("fap_stallreq", 64'(stallreq_o), 64'h0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) begin
        mem_rand = (k % 1000 == 0);
        mem_lat  = $urandom_range(0, 2);
      end
      step($urandom_range(0, 3) != 0, {$urandom_range(0, 65535), 2'b00} & 32'hFFFF_FFFC,
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
